// File: rtl/fifo_pkg.sv
// Shared constants and pointer-coding helpers for the asynchronous FIFO pointer blocks.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned PTR_W          = ADDR_WIDTH_DEF + 1;

  // Helpers work on 32-bit zero-extended values so any pointer width up to 32 can use them.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int unsigned i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary conversion as an MSB-first XOR prefix chain.
module fifo_gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin            = '0;
    bin[WIDTH-1]   = gray[WIDTH-1];
    for (int unsigned i = 1; i < WIDTH; i++) begin
      bin[WIDTH-1-i] = bin[WIDTH-i] ^ gray[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full, fill level and sticky overflow for the async FIFO.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 3,
  parameter int unsigned ALMOST_FULL_TH = 6
) (
  input  logic                  CLK_Src,
  input  logic                  RST_Src,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RPTR_SYNC,
  input  logic                  OVF_CLR,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   WPTR,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   FILL_LEVEL,
  output logic                  OVERFLOW
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] fill_next;
  logic          accept;
  logic          af_next;

  assign accept     = W_INC & ~FULL;
  assign W_EN       = accept;
  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = PW'(bin2gray(32'(wbin_next)));

  fifo_gray2bin #(.WIDTH(PW)) u_rptr_g2b (
    .gray (RPTR_SYNC),
    .bin  (rbin)
  );

  // Full when the write pointer is exactly one lap ahead: Gray form flips the top two bits.
  assign full_cmp  = RPTR_SYNC ^ (PW'(3) << (PW - 2));
  assign fill_next = wbin_next - rbin;
  assign af_next   = (32'(fill_next) >= ALMOST_FULL_TH);

  always_ff @(posedge CLK_Src) begin
    if (RST_Src) begin
      wbin        <= '0;
      WPTR        <= '0;
      W_ADDR      <= '0;
      FULL        <= 1'b0;
      ALMOST_FULL <= 1'b0;
      FILL_LEVEL  <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      WPTR        <= wgray_next;
      W_ADDR      <= wbin_next[ADDR_WIDTH-1:0];
      FULL        <= (wgray_next == full_cmp);
      ALMOST_FULL <= af_next;
      FILL_LEVEL  <= fill_next;
      if (W_INC & FULL) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full: driver queues expectations, negedge monitor checks them.
module tb_fifo_wptr_full;

  logic       CLK_Src = 1'b0;
  logic       RST_Src = 1'b1;
  logic       W_INC   = 1'b1;
  logic [3:0] RPTR_SYNC = 4'd0;
  logic       OVF_CLR = 1'b0;
  logic       W_EN;
  logic [2:0] W_ADDR;
  logic [3:0] WPTR;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] FILL_LEVEL;
  logic       OVERFLOW;

  fifo_wptr_full #(.ADDR_WIDTH(3), .ALMOST_FULL_TH(6)) dut (
    .CLK_Src     (CLK_Src),
    .RST_Src     (RST_Src),
    .W_INC       (W_INC),
    .RPTR_SYNC   (RPTR_SYNC),
    .OVF_CLR     (OVF_CLR),
    .W_EN        (W_EN),
    .W_ADDR      (W_ADDR),
    .WPTR        (WPTR),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .FILL_LEVEL  (FILL_LEVEL),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK_Src = ~CLK_Src;

  typedef struct {
    int tag;
    int phase;
    bit is_wen;
    int wen;
    int wptr;
    int waddr;
    int full;
    int af;
    int fill;
    int ovf;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   phase = 0;

  // Hand-written 4-bit Gray sequence indexed by binary count.
  int GT [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  int m_wb = 0, m_full = 0, m_af = 0, m_fill = 0, m_ovf = 0;

  always @(posedge CLK_Src) cyc <= cyc + 1;

  function automatic int gray_to_count(input int g);
    for (int i = 0; i < 16; i++) if (GT[i] == g) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int ph, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s phase %0d cycle %0d: got %0d required %0d", nm, ph, cyc, act, req);
  endtask

  always @(negedge CLK_Src) begin
    while (q.size() > 0 && q[0].tag <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.tag != cyc) chk("sched", e.phase, cyc, e.tag);
      if (e.is_wen) begin
        chk("W_EN", e.phase, int'(W_EN), e.wen);
      end else begin
        chk("WPTR", e.phase, int'(WPTR), e.wptr);
        chk("W_ADDR", e.phase, int'(W_ADDR), e.waddr);
        chk("FULL", e.phase, int'(FULL), e.full);
        chk("ALMOST_FULL", e.phase, int'(ALMOST_FULL), e.af);
        chk("FILL_LEVEL", e.phase, int'(FILL_LEVEL), e.fill);
        chk("OVERFLOW", e.phase, int'(OVERFLOW), e.ovf);
      end
    end
  end

  task automatic step(input bit rst, input bit winc, input bit clr, input logic [3:0] rptr);
    exp_t e;
    int   k, acc, rb;
    @(posedge CLK_Src);
    #1;
    RST_Src   = rst;
    W_INC     = winc;
    OVF_CLR   = clr;
    RPTR_SYNC = rptr;
    k = cyc;
    e = '{default: 0};
    e.tag = k; e.phase = phase; e.is_wen = 1'b1;
    e.wen = (winc && !m_full) ? 1 : 0;
    q.push_back(e);
    if (rst) begin
      m_wb = 0; m_full = 0; m_af = 0; m_fill = 0; m_ovf = 0;
    end else begin
      acc = (winc && !m_full) ? 1 : 0;
      if (winc && m_full) m_ovf = 1;
      else if (clr) m_ovf = 0;
      m_wb   = (m_wb + acc) % 16;
      rb     = gray_to_count(int'(rptr));
      m_fill = (m_wb - rb + 16) % 16;
      m_full = (m_fill == 8) ? 1 : 0;
      m_af   = (m_fill >= 6) ? 1 : 0;
    end
    e = '{default: 0};
    e.tag = k + 1; e.phase = phase; e.is_wen = 1'b0;
    e.wptr = GT[m_wb]; e.waddr = m_wb % 8;
    e.full = m_full; e.af = m_af; e.fill = m_fill; e.ovf = m_ovf;
    q.push_back(e);
  endtask

  initial begin
    int p1, p2;
    // 1: reset holds everything at zero despite W_INC
    phase = 1;
    repeat (2) step(1, 1, 0, 4'd0);
    // 2: fill from empty, read pointer parked at 0
    phase = 2;
    repeat (8) step(0, 1, 0, 4'd0);
    // 3: overflow set, set beats clear, clear alone
    phase = 3;
    step(0, 1, 0, 4'd0);
    step(0, 1, 1, 4'd0);
    step(0, 0, 1, 4'd0);
    // 4: release as the read pointer advances
    phase = 4;
    step(0, 0, 0, 4'd1);
    step(0, 0, 0, 4'd3);
    step(0, 0, 0, 4'd2);
    // 5: wrap with the read pointer trailing two edges
    phase = 5;
    step(1, 0, 0, 4'd0);
    p1 = 0; p2 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 4'(GT[p2]));
      p2 = p1;
      p1 = m_wb;
    end
    // 6: reset while full and overflowed, then first write
    phase = 6;
    step(1, 0, 0, 4'd0);
    repeat (9) step(0, 1, 0, 4'd0);
    step(1, 1, 0, 4'd0);
    step(0, 1, 0, 4'd0);
    step(0, 0, 0, 4'd0);
    repeat (2) @(negedge CLK_Src);
    #1;
    chk("queue_drained", phase, q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout required completion");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

endmodule
